// File: rtl/data_mem_responder.sv
// Responder for MEM-stage data-memory requests: word-addressed array with a fixed
// multi-cycle access time, pipeline freeze while busy, and a one-cycle ready pulse.
module data_mem_responder #(
   parameter int WAIT_CYCLES = 4,
   parameter int DEPTH       = 64,
   parameter int BASE_ADDR   = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MEM_R_EN,
   input  logic        MEM_W_EN,
   input  logic [31:0] addr,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        ready,
   output logic        freeze,
   output logic        addr_err
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic           is_wr_q, is_wr_d;
   logic           both_q, both_d;
   logic           oob_q, oob_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [31:0]    wdata_q, wdata_d;
   logic [31:0]    rd_data_q, rd_data_d;
   logic           ready_q, ready_d;
   logic           addr_err_q, addr_err_d;
   logic [31:0]    mem_q [DEPTH];
   logic           mem_we_s;

   logic           req_s;
   logic [31:0]    off_s;
   logic [31:0]    word_s;
   logic           oob_s;
   logic           last_s;

   // Address decode: the low two address bits are dropped by the word shift.
   assign req_s  = MEM_R_EN | MEM_W_EN;
   assign off_s  = addr - 32'(BASE_ADDR);
   assign word_s = {2'b00, off_s[31:2]};
   assign oob_s  = (addr < 32'(BASE_ADDR)) || (word_s >= 32'(DEPTH));
   assign last_s = (cnt_q == 4'(WAIT_CYCLES - 1));

   // Next-state and completion logic; ready/addr_err are only raised on the edge into DONE.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      is_wr_d    = is_wr_q;
      both_d     = both_q;
      oob_d      = oob_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      rd_data_d  = rd_data_q;
      ready_d    = 1'b0;
      addr_err_d = 1'b0;
      mem_we_s   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_s) begin
               is_wr_d = MEM_W_EN;
               both_d  = MEM_R_EN & MEM_W_EN;
               oob_d   = oob_s;
               idx_d   = word_s[IW-1:0];
               wdata_d = wr_data;
               cnt_d   = 4'd0;
               state_d = ACCESS;
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS: begin
            cnt_d = cnt_q + 4'd1;
            if (last_s) begin
               state_d    = DONE;
               ready_d    = 1'b1;
               addr_err_d = oob_q;
               if (is_wr_q) begin
                  mem_we_s = ~oob_q;
                  // A combined read+write request reports zero read data.
                  if (both_q) begin
                     rd_data_d = 32'd0;
                  end else begin
                     rd_data_d = rd_data_q;
                  end
               end else if (oob_q) begin
                  rd_data_d = 32'd0;
               end else begin
                  rd_data_d = mem_q[idx_q];
               end
            end else begin
               state_d = ACCESS;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         is_wr_q    <= 1'b0;
         both_q     <= 1'b0;
         oob_q      <= 1'b0;
         idx_q      <= '0;
         wdata_q    <= 32'd0;
         rd_data_q  <= 32'd0;
         ready_q    <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         is_wr_q    <= is_wr_d;
         both_q     <= both_d;
         oob_q      <= oob_d;
         idx_q      <= idx_d;
         wdata_q    <= wdata_d;
         rd_data_q  <= rd_data_d;
         ready_q    <= ready_d;
         addr_err_q <= addr_err_d;
      end
   end

   // Data array is not cleared by reset; a write in flight during reset is dropped.
   always_ff @(posedge clk) begin
      if (mem_we_s && !rst) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

   assign rd_data  = rd_data_q;
   assign ready    = ready_q;
   assign addr_err = addr_err_q;
   assign freeze   = req_s & ~ready_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: vector table plus hand sequences for reset and back-to-back,
// with a scoreboard queue checked whenever ready pulses.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_r_en = 1'b0;
   logic        mem_w_en = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wr_data = 32'd0;
   logic [31:0] rd_data;
   logic        ready;
   logic        freeze;
   logic        addr_err;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [31:0] rd;
      logic        err;
   } exp_t;

   vec_t vecs[16];
   exp_t sb[$];

   data_mem_responder #(.WAIT_CYCLES(4), .DEPTH(64), .BASE_ADDR(1024)) dut (
      .clk      (clk),
      .rst      (rst),
      .MEM_R_EN (mem_r_en),
      .MEM_W_EN (mem_w_en),
      .addr     (addr),
      .wr_data  (wr_data),
      .rd_data  (rd_data),
      .ready    (ready),
      .freeze   (freeze),
      .addr_err (addr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every ready pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      exp_t e;
      if (ready === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ready: got ready=1 want no pending request at %0t", $time);
         end else begin
            e = sb.pop_front();
            chk("rd_data", rd_data, e.rd);
            chk("addr_err", {31'd0, addr_err}, {31'd0, e.err});
         end
      end
   end

   task automatic wait_done(input int lat);
      bit seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (ready === 1'b1) begin
            seen = 1'b1;
            chk("latency", c, lat);
            chk("freeze_at_ready", {31'd0, freeze}, 32'd0);
         end else if (c < lat) begin
            chk("freeze_busy", {31'd0, freeze}, 32'd1);
         end
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL ready_timeout: got no ready want ready after %0d cycles", lat);
      end
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
      mem_r_en = rd;
      mem_w_en = wr;
      addr     = a;
      wr_data  = d;
   endtask

   task automatic do_req(input vec_t v);
      @(posedge clk); #1;
      drive(v.rd, v.wr, v.a, v.d);
      sb.push_back('{v.exp_rd, v.exp_err});
      wait_done(5);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 32'h00000000, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 32'd1030, 32'h0,        32'hDEADBEEF, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 32'd1024, 32'hA5A50000, 32'hDEADBEEF, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 32'd1276, 32'h00005A5A, 32'hDEADBEEF, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 32'd1020, 32'h12345678, 32'hDEADBEEF, 1'b1};
      vecs[6]  = '{1'b1, 1'b0, 32'd1280, 32'h0,        32'h00000000, 1'b1};
      vecs[7]  = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hA5A50000, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 32'd1276, 32'h0,        32'h00005A5A, 1'b0};
      vecs[9]  = '{1'b1, 1'b1, 32'd1032, 32'h00000055, 32'h00000000, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'h00000055, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 32'd1036, 32'h11112222, 32'h00000055, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 32'd1036, 32'h0,        32'h11112222, 1'b0};
      vecs[13] = '{1'b1, 1'b0, 32'd1000, 32'h0,        32'h00000000, 1'b1};
      vecs[14] = '{1'b0, 1'b1, 32'd1280, 32'hFFFFFFFF, 32'h00000000, 1'b1};
      vecs[15] = '{1'b1, 1'b0, 32'd1276, 32'h0,        32'h00005A5A, 1'b0};

      // Reset, then idle with no requests.
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_ready", {31'd0, ready}, 32'd0);
         chk("idle_freeze", {31'd0, freeze}, 32'd0);
         chk("idle_rd_data", rd_data, 32'd0);
      end

      for (int i = 0; i < 16; i++) begin
         do_req(vecs[i]);
      end

      // Back-to-back: request held through ready is re-accepted the cycle after DONE.
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 32'd1028, 32'd0);
      sb.push_back('{32'hDEADBEEF, 1'b0});
      sb.push_back('{32'hDEADBEEF, 1'b0});
      wait_done(5);
      wait_done(5);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 32'd0, 32'd0);

      // Write aborted by reset in cycle 2, request dropped with reset.
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 32'd1036, 32'h0000AAAA);
      @(posedge clk); #1;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      drive(1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      chk("post_rst_freeze", {31'd0, freeze}, 32'd0);
      chk("post_rst_rd_data", rd_data, 32'd0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("aborted_no_ready", {31'd0, ready}, 32'd0);
      end
      do_req('{1'b1, 1'b0, 32'd1036, 32'h0, 32'h11112222, 1'b0});

      // Read held across reset restarts and completes WAIT+1 cycles after reset.
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 32'd1036, 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      sb.push_back('{32'h11112222, 1'b0});
      wait_done(5);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 32'd0, 32'd0);

      repeat (10) @(posedge clk);
      chk("sb_drained", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
